// File: rtl/ahbl_uart_rx_pkg.sv
// Shared constants for the AHB-Lite UART receiver: register map, STATUS
// layout, default read value and the receiver state encoding.
package ahbl_uart_rx_pkg;

  // Receiver oversampling ratio (ticks per bit). Fixed; the sample counters are 4 bits wide.
  localparam int OVERSAMPLE = 16;

  // Register offsets, decoded on HADDR[23:0]
  localparam logic [23:0] ADDR_CTRL    = 24'h00_0000;
  localparam logic [23:0] ADDR_BAUDDIV = 24'h00_0004;
  localparam logic [23:0] ADDR_STATUS  = 24'h00_0008;
  localparam logic [23:0] ADDR_DATA    = 24'h00_000C;

  // CTRL bit positions
  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  // STATUS bit positions
  localparam int STATUS_RXNE      = 0;
  localparam int STATUS_FULL      = 1;
  localparam int STATUS_OVR       = 2;
  localparam int STATUS_FERR      = 3;
  localparam int STATUS_COUNT_LSB = 4;

  // Value returned for any unmapped address
  localparam logic [31:0] READ_DEFAULT = 32'hBADD_BEEF;

  // Receiver FSM states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 serial deserialiser: two-flop synchroniser, baud tick generator and
// a 16x oversampling receive FSM. Completed bytes are reported as one-cycle
// pulses on valid (good stop bit) or ferr (bad stop bit).
//
// Handshake: valid is a one-cycle strobe with data stable in the same cycle.
// There is no ready/back-pressure; the consumer must take or drop the byte
// in that cycle.
module uart_rx
  import ahbl_uart_rx_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] baud_div,
  input  logic        rx,
  output logic [7:0]  data,
  output logic        valid,
  output logic        ferr,
  output rx_state_t   state
);

  localparam logic [3:0] SC_MID  = 4'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0] SC_LAST = 4'(OVERSAMPLE - 1);

  logic        rx_meta;
  logic        rx_s;
  logic [15:0] tick_cnt;
  logic        tick;

  rx_state_t   state_next;
  logic [3:0]  sc;
  logic [3:0]  sc_next;
  logic [2:0]  bc;
  logic [2:0]  bc_next;
  logic [7:0]  shreg;
  logic [7:0]  shreg_next;
  logic        valid_d;
  logic        ferr_d;

  // Bring the asynchronous line into the clock domain; idle level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Down-counter producing one tick every baud_div+1 cycles; parked while disabled.
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      tick_cnt <= baud_div;
    end else if (tick_cnt == 16'd0) begin
      tick_cnt <= baud_div;
    end else begin
      tick_cnt <= tick_cnt - 16'd1;
    end
  end

  assign tick = en && (tick_cnt == 16'd0);

  // State register together with the sample/bit counters and shift register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RX_IDLE;
      sc    <= 4'd0;
      bc    <= 3'd0;
      shreg <= 8'd0;
    end else begin
      state <= state_next;
      sc    <= sc_next;
      bc    <= bc_next;
      shreg <= shreg_next;
    end
  end

  // Next-state logic: start detect, mid-start glitch filter, mid-bit sampling.
  always_comb begin
    state_next = state;
    sc_next    = sc;
    bc_next    = bc;
    shreg_next = shreg;
    if (!en) begin
      state_next = RX_IDLE;
      sc_next    = 4'd0;
      bc_next    = 3'd0;
    end else begin
      case (state)
        RX_IDLE: begin
          if (!rx_s) begin
            state_next = RX_START;
            sc_next    = 4'd0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (sc == SC_MID) begin
              if (rx_s) begin
                state_next = RX_IDLE;
              end else begin
                state_next = RX_DATA;
                sc_next    = 4'd0;
                bc_next    = 3'd0;
              end
            end else begin
              sc_next = sc + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (sc == SC_LAST) begin
              shreg_next = {rx_s, shreg[7:1]};
              sc_next    = 4'd0;
              if (bc == 3'd7) begin
                state_next = RX_STOP;
              end else begin
                bc_next = bc + 3'd1;
              end
            end else begin
              sc_next = sc + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (sc == SC_LAST) begin
              state_next = RX_IDLE;
            end else begin
              sc_next = sc + 4'd1;
            end
          end
        end
        default: state_next = RX_IDLE;
      endcase
    end
  end

  // Output decode: classify the frame at the stop-bit sample point.
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if ((state == RX_STOP) && tick && (sc == SC_LAST)) begin
      valid_d = rx_s;
      ferr_d  = !rx_s;
    end
  end

  // Register the frame result so the byte is presented one cycle after the stop sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ferr  <= 1'b0;
      data  <= 8'd0;
    end else begin
      valid <= valid_d;
      ferr  <= ferr_d;
      if (valid_d) begin
        data <= shreg;
      end
    end
  end

endmodule

// File: rtl/ahbl_uart_rx.sv
// AHB-Lite UART receiver peripheral: register file (CTRL, BAUDDIV, STATUS,
// DATA), receive FIFO and interrupt, wrapped around the uart_rx core.
module ahbl_uart_rx
  import ahbl_uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        rx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW + 1)'(FIFO_DEPTH);

  // Latched address phase
  logic [23:0] haddr_d;
  logic [1:0]  htrans_d;
  logic        hwrite_d;
  logic [2:0]  hsize_d;
  logic        wr_en;
  logic        rd_en;

  // Registers
  logic [1:0]  ctrl;
  logic [15:0] baud_div;
  logic        ovr;
  logic        ferr_flag;

  // Receiver interface
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ferr;
  rx_state_t   rx_state;

  // FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [7:0]    head;
  logic [31:0]   status_word;

  logic ovr_set;
  logic ovr_clr;
  logic ferr_clr;
  logic unused_bits;

  assign HREADYOUT = 1'b1;

  // Capture the address phase whenever the bus advances.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      haddr_d  <= 24'd0;
      htrans_d <= 2'b00;
      hwrite_d <= 1'b0;
      hsize_d  <= 3'd0;
    end else if (HREADY) begin
      haddr_d  <= HADDR[23:0];
      htrans_d <= HTRANS;
      hwrite_d <= HWRITE;
      hsize_d  <= HSIZE;
    end
  end

  assign wr_en = htrans_d[1] & hwrite_d;
  assign rd_en = htrans_d[1] & ~hwrite_d;

  // Writable configuration registers.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ctrl     <= 2'b00;
      baud_div <= 16'd0;
    end else if (wr_en) begin
      if (haddr_d == ADDR_CTRL) begin
        ctrl <= HWDATA[1:0];
      end
      if (haddr_d == ADDR_BAUDDIV) begin
        baud_div <= HWDATA[15:0];
      end
    end
  end

  uart_rx u_rx (
    .clk      (HCLK),
    .rst      (HRESET),
    .en       (ctrl[CTRL_EN]),
    .baud_div (baud_div),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .ferr     (rx_ferr),
    .state    (rx_state)
  );

  assign empty = (count == '0);
  assign full  = (count == COUNT_FULL);
  assign head  = mem[rd_ptr];

  // A full FIFO still accepts a byte when the head is popped in the same cycle.
  assign pop     = rd_en && (haddr_d == ADDR_DATA) && !empty;
  assign push    = rx_valid && (!full || pop);
  assign ovr_set = rx_valid && full && !pop;

  assign ovr_clr  = wr_en && (haddr_d == ADDR_STATUS) && HWDATA[STATUS_OVR];
  assign ferr_clr = wr_en && (haddr_d == ADDR_STATUS) && HWDATA[STATUS_FERR];

  // Sticky error flags; a set event in the same cycle beats a write-1-clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      ovr       <= 1'b0;
      ferr_flag <= 1'b0;
    end else begin
      ovr       <= (ovr & ~ovr_clr) | ovr_set;
      ferr_flag <= (ferr_flag & ~ferr_clr) | rx_ferr;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge HCLK) begin
    if (push) begin
      mem[wr_ptr] <= rx_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Assemble the STATUS word from live FIFO state and the sticky flags.
  always_comb begin
    status_word                                 = 32'd0;
    status_word[STATUS_RXNE]                    = !empty;
    status_word[STATUS_FULL]                    = full;
    status_word[STATUS_OVR]                     = ovr;
    status_word[STATUS_FERR]                    = ferr_flag;
    status_word[STATUS_COUNT_LSB +: (AW + 1)]   = count;
  end

  // Read mux driven from the latched data-phase address.
  always_comb begin
    HRDATA = READ_DEFAULT;
    case (haddr_d)
      ADDR_CTRL:    HRDATA = {30'd0, ctrl};
      ADDR_BAUDDIV: HRDATA = {16'd0, baud_div};
      ADDR_STATUS:  HRDATA = status_word;
      ADDR_DATA:    HRDATA = empty ? 32'd0 : {24'd0, head};
      default:      HRDATA = READ_DEFAULT;
    endcase
  end

  assign irq = ctrl[CTRL_IE] & !empty;

  // Bus fields and debug state that the register logic does not consume.
  assign unused_bits = ^{HADDR[31:24], hsize_d, HWDATA[31:16], rx_state};

endmodule

// File: tb/tb_ahbl_uart_rx.sv
// Bench for ahbl_uart_rx: bus and serial driver tasks, a byte-queue model of
// the receive FIFO with sticky flags, and one task per scenario.
module tb_ahbl_uart_rx;

  localparam int DEPTH      = 4;
  localparam int BIT_CYCLES = 32;   // BAUDDIV=1 -> 2 cycles/tick, 16 ticks/bit

  localparam logic [31:0] A_CTRL   = 32'h0000_0000;
  localparam logic [31:0] A_BAUD   = 32'h0000_0004;
  localparam logic [31:0] A_STATUS = 32'h0000_0008;
  localparam logic [31:0] A_DATA   = 32'h0000_000C;
  localparam logic [31:0] A_UNMAP  = 32'h0000_0010;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        rx;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  // Reference model: bytes the receiver should currently hold, plus flags
  logic [7:0] exp_q[$];
  bit         model_ovr;
  bit         model_ferr;
  bit         model_ie;

  ahbl_uart_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .rx        (rx),
    .irq       (irq)
  );

  // ---------------- clock ----------------
  always #5 HCLK = ~HCLK;

  // ---------------- model ----------------
  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    int n;
    n    = exp_q.size();
    s    = 32'(n) << 4;
    s[0] = (n != 0);
    s[1] = (n == DEPTH);
    s[2] = model_ovr;
    s[3] = model_ferr;
    return s;
  endfunction

  function automatic logic exp_irq();
    return model_ie && (exp_q.size() != 0);
  endfunction

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good) begin
      model_ferr = 1'b1;
    end else if (exp_q.size() < DEPTH) begin
      exp_q.push_back(b);
    end else begin
      model_ovr = 1'b1;
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    model_ovr  = 1'b0;
    model_ferr = 1'b0;
    model_ie   = 1'b0;
  endtask

  function automatic logic [31:0] model_pop();
    if (exp_q.size() == 0) return 32'd0;
    return {24'd0, exp_q.pop_front()};
  endfunction

  // ---------------- drivers (called and returning at a negedge) ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    @(negedge HCLK);
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HWDATA = v;
    @(negedge HCLK);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    HADDR  = a;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    @(negedge HCLK);
    HTRANS = 2'b00;
    d      = HRDATA;
    @(negedge HCLK);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // A bad stop bit is a short break covering the stop midpoint, followed by
  // an extra idle bit so the line is quiet before the next start bit.
  task automatic send_frame(input logic [7:0] b, input bit good);
    logic [8:0] bits;
    bits = {b, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx = bits[i];
      repeat (BIT_CYCLES) @(negedge HCLK);
    end
    if (good) begin
      rx = 1'b1;
      repeat (BIT_CYCLES) @(negedge HCLK);
    end else begin
      rx = 1'b0;
      repeat (BIT_CYCLES * 3 / 4) @(negedge HCLK);
      rx = 1'b1;
      repeat (BIT_CYCLES / 4 + BIT_CYCLES) @(negedge HCLK);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] d;
    HRESET = 1'b1;
    idle(3);
    HRESET = 1'b0;
    model_clear();
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++;
    if (HREADYOUT !== 1'b1) begin failures++; $display("FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
    bus_read(A_CTRL, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    bus_read(A_BAUD, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_bauddiv: got %h expected 00000000", d); end
    bus_read(A_STATUS, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_status: got %h expected 00000000", d); end
    bus_read(A_DATA, d);
    checks++;
    if (d !== 32'd0) begin failures++; $display("FAIL reset_data: got %h expected 00000000", d); end
    bus_read(A_UNMAP, d);
    checks++;
    if (d !== 32'hBADDBEEF) begin failures++; $display("FAIL reset_unmapped: got %h expected baddbeef", d); end
  endtask

  task automatic test_single_byte();
    logic [31:0] d;
    logic [31:0] e;
    bus_write(A_BAUD, 32'd1);
    bus_read(A_BAUD, d);
    checks++;
    if (d !== 32'd1) begin failures++; $display("FAIL baud_readback: got %h expected 00000001", d); end
    bus_write(A_CTRL, 32'h3);
    model_ie = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        // Just before the stop-bit midpoint nothing may be visible yet
        idle(BIT_CYCLES * 9 + BIT_CYCLES / 2 - 4);
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL single_irq_early: got %b expected 0", irq); end
      end
    join
    model_frame(8'hA5, 1'b1);
    idle(4);
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL single_irq: got %b expected %b", irq, exp_irq()); end
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL single_status: got %h expected %h", d, e); end
    bus_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL single_data: got %h expected %h", d, e); end
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL single_status_after: got %h expected %h", d, e); end
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL single_irq_after: got %b expected %b", irq, exp_irq()); end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    logic [31:0] e;
    for (int i = 1; i <= 5; i++) begin
      send_frame(8'(i), 1'b1);
      model_frame(8'(i), 1'b1);
    end
    idle(4);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL overrun_status: got %h expected %h", d, e); end
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(A_DATA, d);
      e = model_pop();
      checks++;
      if (d !== e) begin failures++; $display("FAIL overrun_data%0d: got %h expected %h", i, d, e); end
    end
    bus_write(A_STATUS, 32'h4);
    model_ovr = 1'b0;
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL overrun_clear: got %h expected %h", d, e); end
  endtask

  task automatic test_framing();
    logic [31:0] d;
    logic [31:0] e;
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    idle(4);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ferr_status: got %h expected %h", d, e); end
    send_frame(8'h7E, 1'b1);
    model_frame(8'h7E, 1'b1);
    idle(4);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ferr_next_status: got %h expected %h", d, e); end
    bus_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ferr_next_data: got %h expected %h", d, e); end
    bus_write(A_STATUS, 32'h8);
    model_ferr = 1'b0;
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL ferr_clear: got %h expected %h", d, e); end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic [31:0] e;
    rx = 1'b0;
    idle(8);            // 4 ticks at BAUDDIV=1
    rx = 1'b1;
    idle(BIT_CYCLES * 12);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL glitch_status: got %h expected %h", d, e); end
  endtask

  task automatic test_en_abort();
    logic [31:0] d;
    logic [31:0] e;
    fork
      send_frame(8'h96, 1'b1);
      begin
        idle(BIT_CYCLES * 4 + BIT_CYCLES / 2);   // middle of data bit 3
        bus_write(A_CTRL, 32'h2);
      end
    join
    idle(8);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL abort_status: got %h expected %h", d, e); end
    bus_write(A_CTRL, 32'h3);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    idle(4);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL abort_resume_status: got %h expected %h", d, e); end
    bus_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL abort_resume_data: got %h expected %h", d, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] e;
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    idle(4);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rstmid_pre_status: got %h expected %h", d, e); end
    fork
      send_frame(8'hE1, 1'b1);   // bits 5..7 and stop are high: quiet tail
      begin
        idle(BIT_CYCLES * 6 + BIT_CYCLES / 2);   // middle of data bit 5
        HRESET = 1'b1;
        idle(1);
        HRESET = 1'b0;
        model_clear();
        bus_write(A_BAUD, 32'd1);
        bus_write(A_CTRL, 32'h3);
        model_ie = 1'b1;
      end
    join
    idle(BIT_CYCLES);
    bus_read(A_STATUS, d);
    e = exp_status();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rstmid_status: got %h expected %h", d, e); end
    checks++;
    if (irq !== exp_irq()) begin failures++; $display("FAIL rstmid_irq: got %b expected %b", irq, exp_irq()); end
    bus_read(A_DATA, d);
    e = model_pop();
    checks++;
    if (d !== e) begin failures++; $display("FAIL rstmid_data: got %h expected %h", d, e); end
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic [31:0] e;
    logic [7:0]  b;
    bit          good;
    int          k;
    int          nrd;
    for (int r = 0; r < 5; r++) begin
      k = $urandom_range(1, 5);
      for (int j = 0; j < k; j++) begin
        b    = 8'($urandom_range(0, 255));
        good = ($urandom_range(0, 3) != 0);
        send_frame(b, good);
        model_frame(b, good);
      end
      idle(4);
      bus_read(A_STATUS, d);
      e = exp_status();
      checks++;
      if (d !== e) begin failures++; $display("FAIL rand%0d_status: got %h expected %h", r, d, e); end
      checks++;
      if (irq !== exp_irq()) begin failures++; $display("FAIL rand%0d_irq: got %b expected %b", r, irq, exp_irq()); end
      nrd = $urandom_range(0, DEPTH + 1);
      for (int j = 0; j < nrd; j++) begin
        bus_read(A_DATA, d);
        e = model_pop();
        checks++;
        if (d !== e) begin failures++; $display("FAIL rand%0d_data%0d: got %h expected %h", r, j, d, e); end
      end
      bus_write(A_STATUS, 32'hC);
      model_ovr  = 1'b0;
      model_ferr = 1'b0;
      bus_read(A_STATUS, d);
      e = exp_status();
      checks++;
      if (d !== e) begin failures++; $display("FAIL rand%0d_status_after: got %h expected %h", r, d, e); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    HRESET = 1'b1;
    HADDR  = 32'd0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HSIZE  = 3'b010;
    HWDATA = 32'd0;
    HREADY = 1'b1;
    rx     = 1'b1;
    model_clear();
    @(negedge HCLK);
    test_reset();
    test_single_byte();
    test_overrun();
    test_framing();
    test_glitch();
    test_en_abort();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time bound
  initial begin
    #5_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
